// File: rtl/decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage: instruction register, RF operand capture with write-back bypass
// and load-use hazard bubbling into the ID/EX registers.   Revision: 1.0
// ----------------------------------------------------------------------------
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       InInstr,
    input  logic              InValid,
    output logic              InReady,
    output logic [ADDR_W-1:0] Ard1,
    output logic [ADDR_W-1:0] Ard2,
    input  logic [DATA_W-1:0] RfData1,
    input  logic [DATA_W-1:0] RfData2,
    input  logic              WbWrEn,
    input  logic [ADDR_W-1:0] WbAwr,
    input  logic [DATA_W-1:0] WbDin,
    input  logic              Flush,
    input  logic              ExStall,
    output logic              ExValid,
    output logic [DATA_W-1:0] ExA,
    output logic [DATA_W-1:0] ExB,
    output logic [DATA_W-1:0] ExImm,
    output logic [ADDR_W-1:0] ExRd,
    output logic [5:0]        ExFunct,
    output logic              ExRegWrite,
    output logic              ExMemRead,
    output logic              ExMemWrite,
    output logic              ExAluSrc,
    output logic              ExBranch
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    logic [31:0]       ir;
    logic              ir_valid;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] dest;
    logic              dec_reg_write;
    logic              dec_mem_read;
    logic              dec_mem_write;
    logic              dec_alu_src;
    logic              dec_branch;
    logic              uses_rt;
    logic              reg_write;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm_ext;
    logic              hazard;
    logic              advance;
    logic              accept;

    assign rs   = ir[25:21];
    assign rt   = ir[20:16];
    assign Ard1 = rs;
    assign Ard2 = rt;

    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_alu_src   = 1'b0;
        dec_branch    = 1'b0;
        uses_rt       = 1'b0;
        dest          = '0;
        case (ir[31:26])
            OP_RTYPE: begin
                dec_reg_write = 1'b1;
                uses_rt       = 1'b1;
                dest          = ir[15:11];
            end
            OP_LW: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_alu_src   = 1'b1;
                dest          = rt;
            end
            OP_SW: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_ADDI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dest          = rt;
            end
            OP_BEQ: begin
                dec_branch    = 1'b1;
                uses_rt       = 1'b1;
            end
            default: ;
        endcase
    end

    // Writes to r0 are architecturally discarded, so never advertise them.
    assign reg_write = dec_reg_write && (dest != '0);
    assign imm_ext   = {{(DATA_W-16){ir[15]}}, ir[15:0]};

    // The RF commits on the same edge we sample, so forward the write-back value.
    assign op_a = (WbWrEn && (WbAwr != '0) && (WbAwr == rs)) ? WbDin : RfData1;
    assign op_b = (WbWrEn && (WbAwr != '0) && (WbAwr == rt)) ? WbDin : RfData2;

    assign hazard  = ExValid && ExMemRead && (ExRd != '0) &&
                     ((ExRd == rs) || (uses_rt && (ExRd == rt)));
    assign advance = ir_valid && !hazard && !ExStall;
    assign InReady = !Flush && (!ir_valid || advance);
    assign accept  = InValid && InReady;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ir       <= '0;
            ir_valid <= 1'b0;
        end else if (Flush) begin
            ir_valid <= 1'b0;
        end else if (accept) begin
            ir       <= InInstr;
            ir_valid <= 1'b1;
        end else if (advance) begin
            ir_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ExValid    <= 1'b0;
            ExA        <= '0;
            ExB        <= '0;
            ExImm      <= '0;
            ExRd       <= '0;
            ExFunct    <= '0;
            ExRegWrite <= 1'b0;
            ExMemRead  <= 1'b0;
            ExMemWrite <= 1'b0;
            ExAluSrc   <= 1'b0;
            ExBranch   <= 1'b0;
        end else if (Flush || (!ExStall && hazard)) begin
            ExValid    <= 1'b0;
            ExRegWrite <= 1'b0;
            ExMemRead  <= 1'b0;
            ExMemWrite <= 1'b0;
            ExAluSrc   <= 1'b0;
            ExBranch   <= 1'b0;
        end else if (!ExStall) begin
            ExValid    <= ir_valid;
            ExA        <= op_a;
            ExB        <= op_b;
            ExImm      <= imm_ext;
            ExRd       <= dest;
            ExFunct    <= ir[5:0];
            ExRegWrite <= reg_write     && ir_valid;
            ExMemRead  <= dec_mem_read  && ir_valid;
            ExMemWrite <= dec_mem_write && ir_valid;
            ExAluSrc   <= dec_alu_src   && ir_valid;
            ExBranch   <= dec_branch    && ir_valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_decode_stage: directed table, corner sequences and random traffic checked
// against a slot-level model and an in-order issue queue.   Revision: 1.0
// ----------------------------------------------------------------------------
module tb_decode_stage;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              Clk = 1'b0;
    logic              rst_n, in_valid, flush, ex_stall, wb_en;
    logic [31:0]       in_instr;
    logic [ADDR_W-1:0] wb_awr;
    logic [DATA_W-1:0] wb_din;
    logic              InReady, ExValid;
    logic [ADDR_W-1:0] Ard1, Ard2, ExRd;
    logic [DATA_W-1:0] RfData1, RfData2, ExA, ExB, ExImm;
    logic [5:0]        ExFunct;
    logic              ExRegWrite, ExMemRead, ExMemWrite, ExAluSrc, ExBranch;

    always #5 Clk = ~Clk;

    logic [DATA_W-1:0] rf [32];
    assign RfData1 = rf[Ard1];
    assign RfData2 = rf[Ard2];

    decode_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset(rst_n), .InInstr(in_instr), .InValid(in_valid),
        .InReady(InReady), .Ard1(Ard1), .Ard2(Ard2),
        .RfData1(RfData1), .RfData2(RfData2),
        .WbWrEn(wb_en), .WbAwr(wb_awr), .WbDin(wb_din),
        .Flush(flush), .ExStall(ex_stall), .ExValid(ExValid),
        .ExA(ExA), .ExB(ExB), .ExImm(ExImm), .ExRd(ExRd), .ExFunct(ExFunct),
        .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
        .ExAluSrc(ExAluSrc), .ExBranch(ExBranch)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       uses_rt;
        logic [4:0] rd;
        logic [4:0] fl;   // {RegWrite, MemRead, MemWrite, AluSrc, Branch}
    } dec_t;

    typedef struct packed {
        logic        v;
        logic [31:0] a, b, imm;
        logic [4:0]  rd;
        logic [5:0]  fn;
        logic [4:0]  fl;
    } ex_t;

    function automatic dec_t dec(input logic [31:0] ins);
        dec_t d;
        d = '0;
        case (ins[31:26])
            6'h00: begin d.fl = 5'b10000; d.rd = ins[15:11]; d.uses_rt = 1'b1; end
            6'h23: begin d.fl = 5'b11010; d.rd = ins[20:16]; end
            6'h2B: begin d.fl = 5'b00110; d.uses_rt = 1'b1; end
            6'h08: begin d.fl = 5'b10010; d.rd = ins[20:16]; end
            6'h04: begin d.fl = 5'b00001; d.uses_rt = 1'b1; end
            default: ;
        endcase
        if (d.rd == 5'd0) d.fl[4] = 1'b0;
        return d;
    endfunction

    logic [31:0] m_ir;
    logic        m_irv;
    ex_t         m_ex;
    logic [15:0] q[$];
    bit          track_order = 0;

    function automatic logic m_haz();
        dec_t d;
        d = dec(m_ir);
        return m_ex.v && m_ex.fl[3] && (m_ex.rd != 5'd0) &&
               ((m_ex.rd == m_ir[25:21]) || (d.uses_rt && (m_ex.rd == m_ir[20:16])));
    endfunction

    function automatic logic m_ready();
        return !flush && (!m_irv || (!m_haz() && !ex_stall));
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r);
        return (wb_en && wb_awr != 5'd0 && wb_awr == r) ? wb_din : rf[r];
    endfunction

    task automatic model_update(input logic rdy, input logic hz);
        dec_t d;
        d = dec(m_ir);
        if (!rst_n) begin
            m_ir = '0; m_irv = 1'b0; m_ex = '0;
        end else if (flush) begin
            m_irv = 1'b0; m_ex.v = 1'b0; m_ex.fl = '0;
        end else begin
            if (!ex_stall) begin
                if (hz) begin
                    m_ex.v = 1'b0; m_ex.fl = '0;
                end else begin
                    m_ex.v   = m_irv;
                    m_ex.a   = fwd(m_ir[25:21]);
                    m_ex.b   = fwd(m_ir[20:16]);
                    m_ex.imm = {{16{m_ir[15]}}, m_ir[15:0]};
                    m_ex.rd  = d.rd;
                    m_ex.fn  = m_ir[5:0];
                    m_ex.fl  = m_irv ? d.fl : 5'b0;
                end
            end
            if (in_valid && rdy) begin
                m_ir = in_instr; m_irv = 1'b1;
            end else if (m_irv && !hz && !ex_stall) begin
                m_irv = 1'b0;
            end
        end
        if (wb_en && wb_awr != 5'd0) rf[wb_awr] = wb_din;
    endtask

    task automatic compare_all();
        check("in_ready", 32'(InReady), 32'(m_ready()));
        check("ard1", 32'(Ard1), 32'(m_ir[25:21]));
        check("ard2", 32'(Ard2), 32'(m_ir[20:16]));
        check("ex_valid", 32'(ExValid), 32'(m_ex.v));
        check("ex_flags", 32'({ExRegWrite, ExMemRead, ExMemWrite, ExAluSrc, ExBranch}), 32'(m_ex.fl));
        if (m_ex.v) begin
            check("ex_a", ExA, m_ex.a);
            check("ex_b", ExB, m_ex.b);
            check("ex_imm", ExImm, m_ex.imm);
            check("ex_rd", 32'(ExRd), 32'(m_ex.rd));
            check("ex_funct", 32'(ExFunct), 32'(m_ex.fn));
        end
    endtask

    // Inputs must be set before the call; they are held until the following edge.
    task automatic cycle();
        logic rdy, hz;
        @(negedge Clk);
        compare_all();
        rdy = m_ready();
        hz  = m_haz();
        if (track_order && m_ex.v && !ex_stall) begin
            if (q.size() == 0) check("order_underflow", 32'(q.size()), 32'd1);
            else check("order", 32'(ExImm[15:0]), 32'(q.pop_front()));
        end
        @(posedge Clk);
        #1;
        model_update(rdy, hz);
        if (track_order && rst_n && in_valid && rdy) q.push_back(in_instr[15:0]);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [6];
        logic [31:0] ins;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
        ops[3] = 6'h08; ops[4] = 6'h04; ops[5] = 6'($urandom_range(9, 31));
        ins = $urandom;
        ins[31:26] = ops[$urandom_range(0, 5)];
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        ins[15:11] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  flags;
        logic [4:0]  rd;
        logic [31:0] imm;
    } vec_t;

    vec_t tbl [8];

    localparam logic [31:0] ADD_3_1_2 = 32'h00221820;
    localparam logic [31:0] LW_5_0_1  = 32'h8C250000;
    localparam logic [31:0] ADD_6_5_2 = 32'h00A23020;
    localparam logic [31:0] I1 = 32'h20210011;
    localparam logic [31:0] I2 = 32'h20220022;
    localparam logic [31:0] I3 = 32'h20230033;

    initial begin
        tbl[0] = '{32'h2004FFFF, 5'b10010, 5'd4, 32'hFFFFFFFF};  // ADDI r4,r0,-1
        tbl[1] = '{32'h20200005, 5'b00010, 5'd0, 32'h00000005};  // ADDI r0,r1,5
        tbl[2] = '{32'h8C250008, 5'b11010, 5'd5, 32'h00000008};  // LW r5,8(r1)
        tbl[3] = '{32'hAC62FFFC, 5'b00110, 5'd0, 32'hFFFFFFFC};  // SW r2,-4(r3)
        tbl[4] = '{32'h10220010, 5'b00001, 5'd0, 32'h00000010};  // BEQ r1,r2
        tbl[5] = '{32'h00223822, 5'b10000, 5'd7, 32'h00003822};  // SUB r7,r1,r2
        tbl[6] = '{32'h00220020, 5'b00000, 5'd0, 32'h00000020};  // ADD r0,r1,r2
        tbl[7] = '{32'hFC000123, 5'b00000, 5'd0, 32'h00000123};  // unknown opcode

        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h1000 + 32'(i);
        rf[1] = 32'd5;
        rf[2] = 32'd7;

        // Reset held across two edges while fetch offers an instruction.
        rst_n = 1'b0; in_valid = 1'b1; in_instr = ADD_3_1_2;
        flush = 1'b0; ex_stall = 1'b0; wb_en = 1'b0; wb_awr = '0; wb_din = '0;
        @(posedge Clk); #1;
        m_ir = '0; m_irv = 1'b0; m_ex = '0;
        cycle();
        check("rst_valid", 32'(ExValid), 32'd0);
        check("rst_a", ExA, 32'd0);
        check("rst_b", ExB, 32'd0);
        check("rst_imm", ExImm, 32'd0);
        check("rst_rd_funct", 32'({ExRd, ExFunct}), 32'd0);
        check("rst_flags", 32'({ExRegWrite, ExMemRead, ExMemWrite, ExAluSrc, ExBranch}), 32'd0);
        check("rst_ard", 32'({Ard1, Ard2}), 32'd0);

        rst_n = 1'b1;
        #1 check("first_ready", 32'(InReady), 32'd1);
        cycle();
        check("first_accept", 32'({Ard1, Ard2}), 32'({5'd1, 5'd2}));
        in_valid = 1'b0;
        cycle();
        check("add_valid", 32'(ExValid), 32'd1);
        check("add_a", ExA, 32'd5);
        check("add_b", ExB, 32'd7);
        check("add_rd", 32'(ExRd), 32'd3);
        check("add_flags", 32'({ExRegWrite, ExMemRead, ExMemWrite, ExAluSrc, ExBranch}), 32'b10000);

        foreach (tbl[i]) begin
            in_valid = 1'b1; in_instr = tbl[i].instr;
            cycle();
            in_valid = 1'b0;
            cycle();
            check($sformatf("tbl%0d_valid", i), 32'(ExValid), 32'd1);
            check($sformatf("tbl%0d_flags", i),
                  32'({ExRegWrite, ExMemRead, ExMemWrite, ExAluSrc, ExBranch}), 32'(tbl[i].flags));
            check($sformatf("tbl%0d_rd", i), 32'(ExRd), 32'(tbl[i].rd));
            check($sformatf("tbl%0d_imm", i), ExImm, tbl[i].imm);
            check($sformatf("tbl%0d_funct", i), 32'(ExFunct), 32'(tbl[i].imm[5:0]));
        end

        // Load-use: exactly one bubble, then the dependent add picks up the bypass.
        in_valid = 1'b1; in_instr = LW_5_0_1;
        cycle();
        in_instr = ADD_6_5_2;
        cycle();
        in_valid = 1'b0;
        #1 check("lu_ready", 32'(InReady), 32'd0);
        cycle();
        check("lu_bubble", 32'(ExValid), 32'd0);
        wb_en = 1'b1; wb_awr = 5'd5; wb_din = 32'hDEAD;
        cycle();
        wb_en = 1'b0;
        check("lu_valid", 32'(ExValid), 32'd1);
        check("lu_bypass", ExA, 32'hDEAD);
        check("lu_b", ExB, 32'd7);
        check("lu_rd", 32'(ExRd), 32'd6);

        // Three-cycle stall with a full pipeline.
        in_valid = 1'b1; in_instr = I1;
        cycle();
        in_instr = I2;
        cycle();
        ex_stall = 1'b1; in_instr = I3;
        for (int k = 0; k < 3; k++) begin
            #1 check("stall_ready", 32'(InReady), 32'd0);
            cycle();
            check("stall_hold", ExImm, 32'h11);
            check("stall_valid", 32'(ExValid), 32'd1);
        end
        ex_stall = 1'b0;
        cycle();
        check("stall_out2", ExImm, 32'h22);
        in_valid = 1'b0;
        cycle();
        check("stall_out3", ExImm, 32'h33);
        check("stall_out3_v", 32'(ExValid), 32'd1);
        cycle();
        check("stall_nodup", 32'(ExValid), 32'd0);

        // Flush wins over a concurrent stall.
        in_valid = 1'b1; in_instr = I1;
        cycle();
        in_instr = I2;
        cycle();
        ex_stall = 1'b1; flush = 1'b1; in_instr = I3;
        #1 check("flush_ready_lo", 32'(InReady), 32'd0);
        cycle();
        flush = 1'b0; ex_stall = 1'b0; in_valid = 1'b0;
        #1 check("flush_ready", 32'(InReady), 32'd1);
        check("flush_valid", 32'(ExValid), 32'd0);
        cycle();
        check("flush_ir_killed", 32'(ExValid), 32'd0);

        // Random traffic with in-order issue tracking.
        q.delete();
        track_order = 1;
        for (int k = 0; k < 500; k++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_instr = rand_instr();
            ex_stall = ($urandom_range(0, 9) < 3);
            wb_en    = ($urandom_range(0, 2) == 0);
            wb_awr   = 5'($urandom_range(0, 7));
            wb_din   = $urandom;
            cycle();
        end
        in_valid = 1'b0; ex_stall = 1'b0; wb_en = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        check("order_drain", 32'(q.size()), 32'd0);
        track_order = 0;

        // Random traffic including flushes and resets.
        for (int k = 0; k < 300; k++) begin
            rst_n    = ($urandom_range(0, 59) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_instr = rand_instr();
            ex_stall = ($urandom_range(0, 9) < 3);
            wb_en    = ($urandom_range(0, 2) == 0);
            wb_awr   = 5'($urandom_range(0, 7));
            wb_din   = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode pipeline stage that sits directly upstream of the 32x32 register file (RF) and feeds the execute stage.
- Holds the instruction register (IR) and drives the RF read addresses from it.
- Captures the RF read data, with write-back bypass, into ID/EX registers.
- Detects load-use hazards and stalls or inserts bubbles.

Parameters:
- DATA_W, 32, datapath width; must equal RF data width.
- ADDR_W, 5, register address width; must equal RF address width.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- InInstr  in  32  instruction from fetch.
- InValid  in  1  InInstr is valid.
- InReady  out  1  stage accepts InInstr this cycle.
- Ard1  out  ADDR_W  RF read address 1 = IR[25:21] (rs).
- Ard2  out  ADDR_W  RF read address 2 = IR[20:16] (rt).
- RfData1  in  DATA_W  RF Dout1.
- RfData2  in  DATA_W  RF Dout2.
- WbWrEn  in  1  write-back writes the RF this cycle (same signal as RF WrEn).
- WbAwr  in  ADDR_W  write-back address (RF Awr).
- WbDin  in  DATA_W  write-back data (RF Din).
- Flush  in  1  kill the IR and ID/EX contents.
- ExStall  in  1  execute stage cannot accept; hold ID/EX.
- ExValid  out  1  ID/EX holds a real instruction.
- ExA  out  DATA_W  operand rs.
- ExB  out  DATA_W  operand rt.
- ExImm  out  DATA_W  sign-extended IR[15:0].
- ExRd  out  ADDR_W  destination register.
- ExFunct  out  6  IR[5:0].
- ExRegWrite  out  1  control flag.
- ExMemRead  out  1  control flag.
- ExMemWrite  out  1  control flag.
- ExAluSrc  out  1  control flag.
- ExBranch  out  1  control flag.

Behaviour:
- Reset (Reset=0 at a rising edge):
  - IR=0, IrValid=0.
  - All Ex* outputs = 0; ExValid=0.
  - Reset overrides Flush and ExStall.
- Decode of IR[31:26] (opcode):
  - 000000 R-type: RegWrite=1; dest=rd (IR[15:11]); uses rt.
  - 100011 LW: RegWrite=1, MemRead=1, AluSrc=1; dest=rt.
  - 101011 SW: MemWrite=1, AluSrc=1; uses rt; dest=0.
  - 001000 ADDI: RegWrite=1, AluSrc=1; dest=rt.
  - 000100 BEQ: Branch=1; uses rt; dest=0.
  - Any other opcode: all control flags 0, passes through as valid (NOP).
- If dest is register 0, ExRegWrite is forced to 0.
- Bypass (combinational):
  - opA = WbDin if WbWrEn && WbAwr!=0 && WbAwr==rs, else RfData1.
  - opB is the same, using rt and RfData2.
  - Required because the RF writes on the edge while the read is taken the same cycle.
- Hazard (combinational):
  - hazard = ExValid && ExMemRead && ExRd!=0 && (ExRd==rs || (usesRt && ExRd==rt)).
- Advance:
  - advance = IrValid && !hazard && !ExStall.
  - InReady = !Flush && (!IrValid || advance).
- Each rising edge, in priority order:
  1. Reset.
  2. Flush: IrValid=0; ExValid=0 and all control flags 0; the operand registers may keep old values.
  3. ExStall: ID/EX holds every field; IR loads only if IrValid=0 (InReady=1).
  4. hazard: ID/EX takes a bubble (ExValid=0, all control flags 0); IR holds.
  5. Otherwise:
     - ID/EX loads {ExA=opA, ExB=opB, ExImm, ExRd, ExFunct, control flags}.
     - ExValid=IrValid; if IrValid=0, the control flags load as 0.
     - IR loads InInstr when InValid && InReady; otherwise IrValid clears if advance occurred.
- Latency: an instruction accepted at edge N appears on the Ex* outputs after edge N+1, with no hazard or stall.
- Throughput: 1 instruction per cycle.
- A load-use pair costs exactly 1 bubble.
- A stall held any number of cycles must not drop or duplicate an instruction.
- The Ard1/Ard2 outputs are always driven from IR, including while IrValid=0.

Test Plan:
- Reset held low 2 cycles with InValid=1 → ExValid=0, all Ex* outputs 0, IrValid stays 0; the first instruction is accepted on the first edge after Reset=1.
- R-type add r3,r1,r2 with RF r1=5, r2=7 → one edge later: ExA=5, ExB=7, ExRd=3, ExRegWrite=1, ExAluSrc=0, ExValid=1.
- ADDI r4,r0,-1 → ExImm=0xFFFFFFFF, ExRd=4, ExAluSrc=1; ADDI targeting r0 → ExRegWrite=0.
- LW r5,0(r1) followed by add r6,r5,r2 → one bubble cycle (ExValid=0, InReady=0), then the add issues. Once the LW retires, drive WbWrEn=1, WbAwr=5, WbDin=0xDEAD the same cycle the add is in IR → ExA=0xDEAD.
- ExStall held 3 cycles with a full pipeline → Ex* outputs stable, InReady=0; after release, instructions emerge in order with no loss or duplication.
- Flush asserted while ExStall=1 and IrValid=1 → next cycle ExValid=0, IrValid=0, InReady=1.
